// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the memory access unit.
package lc3_mem_pkg;

    // Default number of cycles the memory controls stay asserted.
    localparam int WAIT_CYCLES_DEFAULT = 2;

    // Counter width, wide enough for WAIT_CYCLES-1 with WAIT_CYCLES up to 15.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/mem_access_unit_if.sv
// Datapath/memory-side signal bundle of the memory access unit.
interface mem_access_if;
    logic        LD_MAR;
    logic        LD_MDR;
    logic        MIO_EN;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] bus_input;
    logic [15:0] mem_rdata;
    logic [15:0] MAR;
    logic [15:0] MDR;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_CE;
    logic        mem_OE;
    logic        mem_WE;
    logic        mem_ready;
    logic        busy;

    // The unit itself.
    modport slave (
        input  LD_MAR, LD_MDR, MIO_EN, mem_req, mem_we, bus_input, mem_rdata,
        output MAR, MDR, mem_addr, mem_wdata, mem_CE, mem_OE, mem_WE, mem_ready, busy
    );

    // Whoever drives the controls and the memory model.
    modport master (
        output LD_MAR, LD_MDR, MIO_EN, mem_req, mem_we, bus_input, mem_rdata,
        input  MAR, MDR, mem_addr, mem_wdata, mem_CE, mem_OE, mem_WE, mem_ready, busy
    );
endinterface

// File: rtl/mem_access_unit_reg_16.sv
// 16-bit register with synchronous active-high reset and load enable.
module reg_16 (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ld,
    input  logic [15:0] d,
    output logic [15:0] q
);
    logic [15:0] q_q, q_d;

    // Next value: new data when loading, otherwise hold.
    always_comb begin
        q_d = q_q;
        if (ld) q_d = d;
    end

    // Register with reset priority over load.
    always_ff @(posedge Clk) begin
        if (Reset) q_q <= '0;
        else       q_q <= q_d;
    end

    assign q = q_q;
endmodule

// File: rtl/mem_access_unit.sv
// MAR/MDR pair plus a three-state sequencer that drives one asynchronous
// memory access of WAIT_CYCLES cycles and pulses mem_ready when done.
module mem_access_unit
    import lc3_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
    input  logic         Clk,
    input  logic         Reset,
    mem_access_if.slave  bus
);
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;

    logic               idle, access, last_access;
    logic               mar_ld, mdr_ld;
    logic [15:0]        mdr_src;
    logic [15:0]        mar, mdr;

    assign idle        = (state_q == IDLE);
    assign access      = (state_q == ACCESS);
    assign last_access = access && (cnt_q == '0);

    // Sequencer: accept in IDLE, count down through ACCESS, one DONE cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        unique case (state_q)
            IDLE: begin
                if (bus.mem_req) begin
                    state_d = ACCESS;
                    we_d    = bus.mem_we;
                    cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                end
            end
            ACCESS: begin
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state; reset aborts any access in flight.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
        end
    end

    // Register loads are only honoured in IDLE; the one exception is the
    // read capture on the edge that leaves ACCESS.
    always_comb begin
        mar_ld  = idle && bus.LD_MAR;
        mdr_ld  = (idle && bus.LD_MDR) || (last_access && !we_q);
        mdr_src = bus.bus_input;
        if (last_access || bus.MIO_EN) mdr_src = bus.mem_rdata;
    end

    reg_16 u_mar (
        .Clk   (Clk),
        .Reset (Reset),
        .ld    (mar_ld),
        .d     (bus.bus_input),
        .q     (mar)
    );

    reg_16 u_mdr (
        .Clk   (Clk),
        .Reset (Reset),
        .ld    (mdr_ld),
        .d     (mdr_src),
        .q     (mdr)
    );

    assign bus.MAR       = mar;
    assign bus.MDR       = mdr;
    assign bus.mem_addr  = mar;
    assign bus.mem_wdata = mdr;

    // Controls depend only on registered state and type, never on inputs.
    assign bus.mem_CE    = !access;
    assign bus.mem_OE    = !(access && !we_q);
    assign bus.mem_WE    = !(access && we_q);
    assign bus.mem_ready = (state_q == DONE);
    assign bus.busy      = !idle;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios with literal expectations,
// then random traffic, all compared every cycle against a timeline model.
module tb_mem_access_unit;
    localparam int W = 2;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    mem_access_if ifc ();

    mem_access_unit #(.WAIT_CYCLES(W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (ifc)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Model: an access is just "k cycles since it was accepted".
    // k = 1..W means controls asserted, k = W+1 is the ready cycle.
    logic [15:0] m_mar, m_mdr;
    bit          m_active, m_we;
    int          m_k;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    function automatic logic [4:0] act_ctrl();
        return {ifc.mem_CE, ifc.mem_OE, ifc.mem_WE, ifc.mem_ready, ifc.busy};
    endfunction

    // One clock: advance the model with the inputs present at the edge,
    // then compare every output at the following falling edge.
    task automatic step();
        bit acc, rdy;
        logic [4:0] ec;
        @(posedge Clk);
        if (Reset) begin
            m_mar = 16'h0; m_mdr = 16'h0; m_active = 0; m_we = 0; m_k = 0;
        end else if (!m_active) begin
            if (ifc.LD_MAR) m_mar = ifc.bus_input;
            if (ifc.LD_MDR) m_mdr = ifc.MIO_EN ? ifc.mem_rdata : ifc.bus_input;
            if (ifc.mem_req) begin
                m_active = 1; m_k = 1; m_we = ifc.mem_we;
            end
        end else begin
            if (m_k == W && !m_we) m_mdr = ifc.mem_rdata;
            if (m_k == W + 1) m_active = 0;
            else              m_k++;
        end
        @(negedge Clk);
        acc = m_active && (m_k <= W);
        rdy = m_active && (m_k == W + 1);
        ec  = {~acc, ~(acc && !m_we), ~(acc && m_we), rdy, m_active};
        chk("model_ctrl",  {11'b0, act_ctrl()}, {11'b0, ec});
        chk("model_mar",   ifc.MAR,       m_mar);
        chk("model_mdr",   ifc.MDR,       m_mdr);
        chk("model_addr",  ifc.mem_addr,  m_mar);
        chk("model_wdata", ifc.mem_wdata, m_mdr);
    endtask

    task automatic idle_inputs();
        ifc.LD_MAR = 0; ifc.LD_MDR = 0; ifc.MIO_EN = 0;
        ifc.mem_req = 0; ifc.mem_we = 0;
    endtask

    // ctrl literal order: {CE, OE, WE, ready, busy}
    localparam logic [15:0] C_IDLE  = 16'b11100;
    localparam logic [15:0] C_READ  = 16'b00101;
    localparam logic [15:0] C_WRITE = 16'b01001;
    localparam logic [15:0] C_DONE  = 16'b11111;

    initial begin
        idle_inputs();
        ifc.bus_input = 16'h0; ifc.mem_rdata = 16'h0;
        m_mar = 0; m_mdr = 0; m_active = 0; m_we = 0; m_k = 0;

        // Reset state
        Reset = 1; step();
        chk("rst_ctrl", {11'b0, act_ctrl()}, C_IDLE);
        chk("rst_mar",  ifc.MAR, 16'h0);
        chk("rst_mdr",  ifc.MDR, 16'h0);

        // Load MAR
        Reset = 0; ifc.LD_MAR = 1; ifc.bus_input = 16'h3000; step();
        chk("ldmar_mar",  ifc.MAR,      16'h3000);
        chk("ldmar_addr", ifc.mem_addr, 16'h3000);
        chk("ldmar_ctrl", {11'b0, act_ctrl()}, C_IDLE);

        // Read of 0x1234
        idle_inputs(); ifc.mem_req = 1; ifc.mem_rdata = 16'h1234; step();
        chk("rd_acc1", {11'b0, act_ctrl()}, C_READ);
        ifc.mem_req = 0; step();
        chk("rd_acc2", {11'b0, act_ctrl()}, C_READ);
        step();
        chk("rd_done", {11'b0, act_ctrl()}, C_DONE);
        chk("rd_mdr",  ifc.MDR, 16'h1234);
        step();
        chk("rd_idle", {11'b0, act_ctrl()}, C_IDLE);

        // LD_MDR from bus together with a write request
        ifc.LD_MDR = 1; ifc.bus_input = 16'hBEEF; ifc.mem_req = 1; ifc.mem_we = 1; step();
        chk("wr_wdata", ifc.mem_wdata, 16'hBEEF);
        chk("wr_acc1",  {11'b0, act_ctrl()}, C_WRITE);
        idle_inputs(); step();
        chk("wr_acc2",  {11'b0, act_ctrl()}, C_WRITE);
        step();
        chk("wr_done",  {11'b0, act_ctrl()}, C_DONE);
        step();

        // LD_MAR while busy is ignored; held mem_req gives back-to-back accesses
        ifc.mem_req = 1; ifc.mem_rdata = 16'h5555; step();
        ifc.LD_MAR = 1; ifc.bus_input = 16'h4000; step();
        chk("busy_mar_acc", ifc.MAR, 16'h3000);
        step();
        chk("busy_mar_done", ifc.MAR, 16'h3000);
        chk("b2b_done",      {11'b0, act_ctrl()}, C_DONE);
        step();
        chk("b2b_gap",       {11'b0, act_ctrl()}, C_IDLE);
        step();
        chk("b2b_acc",       {11'b0, act_ctrl()}, C_READ);
        chk("b2b_mar",       ifc.MAR, 16'h4000);
        idle_inputs(); step(); step(); step();

        // Reset in the first ACCESS cycle
        ifc.mem_req = 1; ifc.mem_we = 1; step();
        chk("abort_acc", {11'b0, act_ctrl()}, C_WRITE);
        Reset = 1; ifc.mem_req = 0; step();
        chk("abort_ctrl", {11'b0, act_ctrl()}, C_IDLE);
        chk("abort_mar",  ifc.MAR, 16'h0);
        chk("abort_mdr",  ifc.MDR, 16'h0);
        Reset = 0; idle_inputs(); step();
        chk("abort_noready", {15'b0, ifc.mem_ready}, 16'h0);
        step();

        // LD_MDR from memory data in IDLE
        ifc.LD_MDR = 1; ifc.MIO_EN = 1; ifc.mem_rdata = 16'h00FF; step();
        chk("miomdr_mdr",  ifc.MDR, 16'h00FF);
        chk("miomdr_ctrl", {11'b0, act_ctrl()}, C_IDLE);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            Reset         = ($urandom_range(0, 49) == 0);
            ifc.LD_MAR    = ($urandom_range(0, 3) == 0);
            ifc.LD_MDR    = ($urandom_range(0, 3) == 0);
            ifc.MIO_EN    = $urandom_range(0, 1) == 1;
            ifc.mem_req   = ($urandom_range(0, 2) == 0);
            ifc.mem_we    = $urandom_range(0, 1) == 1;
            ifc.bus_input = 16'($urandom);
            ifc.mem_rdata = 16'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: WAIT_CYCLES, default 2, memory access cycles with controls asserted (legal 1..15).
REQ-002 Clk  input  1  system clock, all state on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 LD_MAR  input  1  load MAR from bus_input.
REQ-005 LD_MDR  input  1  load MDR; source selected by MIO_EN.
REQ-006 MIO_EN  input  1  1: MDR source is mem_rdata; 0: MDR source is bus_input.
REQ-007 mem_req  input  1  start one memory access; sampled only in IDLE.
REQ-008 mem_we  input  1  access type with mem_req: 1 write, 0 read.
REQ-009 bus_input  input  16  shared datapath bus value.
REQ-010 mem_rdata  input  16  data returned by memory.
REQ-011 MAR  output  16  address register.
REQ-012 MDR  output  16  data register; feeds the bus MDR gate input.
REQ-013 mem_addr  output  16  equals MAR at all times.
REQ-014 mem_wdata  output  16  equals MDR at all times.
REQ-015 mem_CE, mem_OE, mem_WE  output  1 each  active-low memory controls.
REQ-016 mem_ready  output  1  one-cycle pulse: access complete.
REQ-017 busy  output  1  high whenever state is not IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, ACCESS and DONE only.
REQ-019 IDLE with mem_req=1 SHALL go to ACCESS, latch mem_we, and load the counter with WAIT_CYCLES-1.
REQ-020 ACCESS SHALL assert mem_CE=0 for its full duration, with mem_OE=0 for a read or mem_WE=0 for a write, and the other control held at 1.
REQ-021 ACCESS SHALL decrement the counter each cycle and go to DONE in the cycle the counter is 0, so ACCESS lasts exactly WAIT_CYCLES cycles.
REQ-022 For a read, MDR SHALL capture mem_rdata on the edge leaving ACCESS.
REQ-023 DONE SHALL assert mem_ready=1 for exactly one cycle, deassert all memory controls, and return to IDLE.
REQ-024 Latency: a request sampled in cycle t gives mem_ready in cycle t+WAIT_CYCLES+1, and the next request is accepted in cycle t+WAIT_CYCLES+2 at the earliest.
REQ-025 In IDLE, LD_MAR and LD_MDR SHALL load on the next edge; mem_req in the same cycle SHALL use the newly loaded MAR/MDR values.
REQ-026 While busy=1, LD_MAR and LD_MDR SHALL be ignored, and MAR/MDR SHALL stay stable except for the read capture in REQ-022.
REQ-027 mem_req outside IDLE SHALL be ignored, with no queuing; a level held through DONE starts a new access from IDLE.
REQ-028 In IDLE, mem_CE, mem_OE and mem_WE SHALL all be 1.
REQ-029 Data paths SHALL be 16-bit with no truncation or extension.

Reset
REQ-030 Reset=1 at a rising edge SHALL force IDLE, MAR=0x0000, MDR=0x0000, counter=0, latched type=read, mem_ready=0, busy=0, and controls=1, overriding all other inputs.
REQ-031 Reset during ACCESS SHALL abort the access and produce no mem_ready pulse; controls SHALL be deasserted from the next cycle.

Structure
REQ-032 Package lc3_mem_pkg SHALL hold the state enum and the WAIT_CYCLES default constant.
REQ-033 MAR and MDR SHALL each use the sub-module reg_16: a 16-bit register with synchronous Reset and load enable.
REQ-034 Memory control outputs SHALL be decoded from the registered state and type only, so they are glitch-free and have no combinational path from inputs.

Verification (WAIT_CYCLES=2)
REQ-035 Reset, then LD_MAR with bus 0x3000 -> MAR=0x3000 and mem_addr=0x3000 next cycle; all other outputs at reset values.
REQ-036 Read at MAR=0x3000 with mem_rdata=0x1234 -> CE/OE low for 2 cycles, WE high; mem_ready pulse in cycle t+3; MDR=0x1234.
REQ-037 LD_MDR (MIO_EN=0, bus 0xBEEF) plus mem_req/mem_we=1 in the same cycle -> mem_wdata=0xBEEF, CE/WE low for 2 cycles, OE high, one mem_ready pulse.
REQ-038 LD_MAR with bus 0x4000 while busy -> MAR keeps 0x3000 until DONE; mem_req held high -> back-to-back accesses with exactly one IDLE cycle between them.
REQ-039 Reset asserted in the 1st ACCESS cycle -> controls high and MAR/MDR=0 next cycle; no mem_ready pulse.
REQ-040 LD_MDR with MIO_EN=1 in IDLE, mem_rdata=0x00FF -> MDR=0x00FF; no memory controls asserted.
